// File: rtl/mult_seq_mnbit.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, M+N-bit product,
// unsigned or two's-complement operands selected per operation, start/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating over multiplier bits, count = 0..N-1
// DONE  | one-cycle result pulse; may accept a new start
module mult_seq_mnbit #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   prod
);

    localparam int W  = M + N;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [M-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic            sgn_r;
    logic [W-1:0]    acc;
    logic [CW-1:0]   count;

    logic [W-1:0]    a_ext;
    logic [W-1:0]    addend;
    logic [W-1:0]    acc_next;
    logic            last;
    logic            accept;

    // In signed mode the multiplier MSB carries weight -2^(N-1), hence the subtract.
    always_comb begin
        a_ext    = sgn_r ? {{N{a_r[M-1]}}, a_r} : {{N{1'b0}}, a_r};
        addend   = a_ext << count;
        last     = (count == CW'(N - 1));
        acc_next = acc;
        if (b_r[count]) begin
            acc_next = (sgn_r && last) ? (acc - addend) : (acc + addend);
        end
    end

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sgn_r <= sgn;
            acc   <= '0;
            count <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == RUN) begin
            acc <= acc_next;
            if (last) begin
                prod  <= acc_next;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_seq_mnbit.sv
// Bench for mult_seq_mnbit: two instances (4x4 and 8x5), queue scoreboard per instance,
// directed cases plus randomized operations against an integer-arithmetic model.
module tb_mult_seq_mnbit;

    localparam int M1 = 4;
    localparam int N1 = 4;
    localparam int M2 = 8;
    localparam int N2 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start1, sgn1, busy1, done1;
    logic [3:0]    a1, b1;
    logic [7:0]    prod1;
    logic          start2, sgn2, busy2, done2;
    logic [7:0]    a2;
    logic [4:0]    b2;
    logic [12:0]   prod2;

    mult_seq_mnbit #(.M(M1), .N(N1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .prod(prod1)
    );

    mult_seq_mnbit #(.M(M2), .N(N2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sgn(sgn2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .prod(prod2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [12:0] p;
        int          c;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [12:0] last1 = '0;
    logic [12:0] last2 = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Product of the operands as integers, reduced modulo 2^(m+n).
    function automatic logic [12:0] model(int m, int n, logic [31:0] a, logic [31:0] b, logic s);
        int va, vb, p;
        va = int'(a);
        vb = int'(b);
        if (s) begin
            if (a[m-1]) va = va - (1 << m);
            if (b[n-1]) vb = vb - (1 << n);
        end
        p = va * vb;
        return 13'(p & ((1 << (m + n)) - 1));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done1_unexpected: got done=1 prod=%0h required no pulse", prod1);
                end else begin
                    e1 = q1.pop_front();
                    chk("prod1", 32'(prod1), 32'(e1.p));
                    chk("done1_cycle", cyc, e1.c);
                    last1 = e1.p;
                end
            end else begin
                chk("prod1_hold", 32'(prod1), 32'(last1));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done2) begin
                if (q2.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done2_unexpected: got done=1 prod=%0h required no pulse", prod2);
                end else begin
                    e2 = q2.pop_front();
                    chk("prod2", 32'(prod2), 32'(e2.p));
                    chk("done2_cycle", cyc, e2.c);
                    last2 = e2.p;
                end
            end else begin
                chk("prod2_hold", 32'(prod2), 32'(last2));
            end
        end
    end

    // Called #1 after an edge; returns #1 after the completion edge (DONE cycle).
    // poke: RUN cycle index at which a conflicting start is pulsed; hold keeps start high.
    task automatic issue1(logic [3:0] a, logic [3:0] b, logic s, int poke, bit hold);
        a1 = a; b1 = b; sgn1 = s; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = hold;
        q1.push_back('{model(M1, N1, 32'(a), 32'(b), s), cyc + N1});
        a1 = 4'($urandom); b1 = 4'($urandom); sgn1 = 1'($urandom);
        for (int k = 0; k < N1; k++) begin
            chk("busy1_run", 32'(busy1), 32'd1);
            if (k == poke) begin
                start1 = 1'b1; a1 = 4'hF; b1 = 4'hF;
            end
            @(posedge clk); #1;
            start1 = hold;
        end
        chk("busy1_done", 32'(busy1), 32'd0);
    endtask

    task automatic issue2(logic [7:0] a, logic [4:0] b, logic s);
        a2 = a; b2 = b; sgn2 = s; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        q2.push_back('{model(M2, N2, 32'(a), 32'(b), s), cyc + N2});
        a2 = 8'($urandom); b2 = 5'($urandom); sgn2 = 1'($urandom);
        for (int k = 0; k < N2; k++) begin
            chk("busy2_run", 32'(busy2), 32'd1);
            @(posedge clk); #1;
        end
        chk("busy2_done", 32'(busy2), 32'd0);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; sgn1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; sgn2 = 1'b0; a2 = '0; b2 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_prod1", 32'(prod1), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_prod2", 32'(prod2), 32'd0);
        rst = 1'b0;
        idle(1);

        issue1(4'hF, 4'hF, 1'b0, -1, 1'b0); idle(1);
        issue1(4'h8, 4'h7, 1'b1, -1, 1'b0); idle(1);
        issue1(4'h8, 4'h8, 1'b1, -1, 1'b0); idle(1);
        issue1(4'h7, 4'hF, 1'b1, -1, 1'b0); idle(1);
        issue1(4'h0, 4'hF, 1'b0, -1, 1'b0); idle(1);
        issue1(4'h0, 4'hF, 1'b1, -1, 1'b0); idle(1);
        issue1(4'h9, 4'h1, 1'b0, -1, 1'b0); idle(1);
        issue1(4'h9, 4'h1, 1'b1, -1, 1'b0); idle(1);
        issue1(4'h3, 4'h5, 1'b0, 1, 1'b0);  idle(2);
        issue1(4'h3, 4'h4, 1'b0, -1, 1'b1);
        issue1(4'h5, 4'h6, 1'b0, -1, 1'b0); idle(1);

        // Asynchronous reset in the second RUN cycle of 6x7.
        a1 = 4'h6; b1 = 4'h7; sgn1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        q1.push_back('{model(M1, N1, 32'd6, 32'd7, 1'b0), cyc + N1});
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy1", 32'(busy1), 32'd0);
        chk("midrst_done1", 32'(done1), 32'd0);
        chk("midrst_prod1", 32'(prod1), 32'd0);
        q1.delete(); last1 = '0;
        q2.delete(); last2 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        issue1(4'h6, 4'h7, 1'b0, -1, 1'b0); idle(1);

        issue2(8'h80, 5'h10, 1'b1); idle(1);
        issue2(8'hFF, 5'h1F, 1'b0); idle(1);
        issue2(8'hFF, 5'h1F, 1'b1); idle(1);

        for (int i = 0; i < 40; i++) begin
            issue1(4'($urandom), 4'($urandom), 1'($urandom),
                   int'($urandom_range(0, 5)) - 1, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 15; i++) begin
            issue2(8'($urandom), 5'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(10);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
